bp_be_late_wb_arbiter: RTL and testbench

//  Shares the single late register-file write port among the long-latency producers:

---
 rtl/bp_be_pkg.sv | 23 ++
 rtl/bp_be_late_wb_buffer.sv | 62 ++++++
 rtl/bp_be_late_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_bp_be_late_wb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Back-end shared types and constants for the late writeback path.
package bp_be_pkg;

  localparam int unsigned late_wb_num_req_lp        = 3;
  localparam int unsigned late_wb_reg_addr_width_lp = 5;
  localparam int unsigned late_wb_data_width_lp     = 66;
  localparam int unsigned late_wb_buf_els_lp        = 2;

  // Producer indices into the late writeback request vectors
  typedef enum logic [1:0] {
    e_late_wb_dcache = 2'd0,
    e_late_wb_idiv   = 2'd1,
    e_late_wb_fdiv   = 2'd2
  } bp_be_late_wb_src_e;

  // One late writeback request as pushed by a producer
  typedef struct packed {
    logic                                 fp;
    logic [late_wb_reg_addr_width_lp-1:0] rd_addr;
    logic [late_wb_data_width_lp-1:0]     data;
  } bp_be_late_wb_req_s;

endpackage

// File: rtl/bp_be_late_wb_buffer.sv
// Small 1r1w FIFO holding pending late writebacks of one producer.
module bp_be_late_wb_buffer #(
  parameter int unsigned width_p = 72,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic                    full_q, full_d;
  logic [width_p-1:0]      mem_q [els_p];
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign empty   = (rptr_q == wptr_q) & ~full_q;
  assign ready_o = ~full_q;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q];
  assign push    = v_i & ~full_q;
  assign pop     = yumi_i & ~empty;

  // Pointer advance with natural wrap; full flag resolves the equal-pointer case
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    full_d = full_q;
    if (push) wptr_d = wptr_q + ptr_width_lp'(1);
    if (pop)  rptr_d = rptr_q + ptr_width_lp'(1);
    if (push & ~pop)      full_d = (wptr_d == rptr_q);
    else if (pop & ~push) full_d = 1'b0;
  end

  // Control state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      full_q <= full_d;
    end
  end

  // Payload storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Round-robin merge of long-latency producers onto the single late regfile write port.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned num_req_p        = late_wb_num_req_lp,
  parameter int unsigned reg_addr_width_p = late_wb_reg_addr_width_lp,
  parameter int unsigned data_width_p     = late_wb_data_width_lp,
  parameter int unsigned buf_els_p        = late_wb_buf_els_lp,
  localparam int unsigned src_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  input  logic [num_req_p-1:0]                  req_fp_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_rd_addr_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  output logic                                  wb_v_o,
  input  logic                                  wb_ready_i,
  output logic                                  wb_fp_o,
  output logic [reg_addr_width_p-1:0]           wb_rd_addr_o,
  output logic [data_width_p-1:0]               wb_data_o,
  output logic [src_width_lp-1:0]               wb_src_o,
  output logic                                  idle_o
);

  localparam int unsigned entry_width_lp = 1 + reg_addr_width_p + data_width_p;

  logic [num_req_p-1:0]      buf_v;
  logic [num_req_p-1:0]      buf_yumi;
  logic [entry_width_lp-1:0] buf_data [num_req_p];

  logic                      wb_v_q, wb_v_d;
  logic [entry_width_lp-1:0] wb_entry_q, wb_entry_d;
  logic [src_width_lp-1:0]   wb_src_q, wb_src_d;
  logic [src_width_lp-1:0]   rr_q, rr_d;

  logic                      grant_v;
  logic [src_width_lp-1:0]   grant_idx;
  logic                      load;

  // One buffer per producer; entries are packed {fp, rd_addr, data}
  for (genvar i = 0; i < int'(num_req_p); i++) begin : g_buf
    bp_be_late_wb_buffer #(
      .width_p (entry_width_lp),
      .els_p   (buf_els_p)
    ) u_buf (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (req_v_i[i]),
      .data_i    ({req_fp_i[i],
                   req_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p],
                   req_data_i[i*data_width_p +: data_width_p]}),
      .ready_o   (req_ready_o[i]),
      .v_o       (buf_v[i]),
      .data_o    (buf_data[i]),
      .yumi_i    (buf_yumi[i])
    );
  end

  // Output register takes a new entry when empty or when its current one retires
  assign load = ~wb_v_q | wb_ready_i;

  // First non-empty buffer at or after the rr pointer, wrapping modulo num_req_p
  always_comb begin
    int unsigned idx;
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned off = 0; off < num_req_p; off++) begin
      idx = 32'(rr_q) + off;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_v && buf_v[src_width_lp'(idx)]) begin
        grant_v   = 1'b1;
        grant_idx = src_width_lp'(idx);
      end
    end
  end

  // Output stage load, head pop and pointer advance
  always_comb begin
    wb_v_d     = wb_v_q;
    wb_entry_d = wb_entry_q;
    wb_src_d   = wb_src_q;
    rr_d       = rr_q;
    buf_yumi   = '0;
    if (load) begin
      wb_v_d = grant_v;
      if (grant_v) begin
        wb_entry_d          = buf_data[grant_idx];
        wb_src_d            = grant_idx;
        buf_yumi[grant_idx] = 1'b1;
        rr_d = (32'(grant_idx) == num_req_p - 1) ? '0 : grant_idx + src_width_lp'(1);
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wb_v_q     <= 1'b0;
      wb_entry_q <= '0;
      wb_src_q   <= '0;
      rr_q       <= '0;
    end else begin
      wb_v_q     <= wb_v_d;
      wb_entry_q <= wb_entry_d;
      wb_src_q   <= wb_src_d;
      rr_q       <= rr_d;
    end
  end

  assign wb_v_o       = wb_v_q;
  assign wb_fp_o      = wb_entry_q[entry_width_lp-1];
  assign wb_rd_addr_o = wb_entry_q[data_width_p +: reg_addr_width_p];
  assign wb_data_o    = wb_entry_q[data_width_p-1:0];
  assign wb_src_o     = wb_src_q;
  assign idle_o       = ~(|buf_v) & ~wb_v_q;

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Directed bench for the late writeback arbiter.
module tb_bp_be_late_wb_arbiter;
  import bp_be_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 66;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_v;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_fp;
  logic [N*RW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            wb_v;
  logic            wb_ready;
  logic            wb_fp;
  logic [RW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic [1:0]      wb_src;
  logic            idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_be_late_wb_arbiter #(
    .num_req_p        (N),
    .reg_addr_width_p (RW),
    .data_width_p     (DW),
    .buf_els_p        (2)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .req_v_i       (req_v),
    .req_ready_o   (req_ready),
    .req_fp_i      (req_fp),
    .req_rd_addr_i (req_rd),
    .req_data_i    (req_data),
    .wb_v_o        (wb_v),
    .wb_ready_i    (wb_ready),
    .wb_fp_o       (wb_fp),
    .wb_rd_addr_o  (wb_rd),
    .wb_data_o     (wb_data),
    .wb_src_o      (wb_src),
    .idle_o        (idle)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic fp, input logic [RW-1:0] rd, input logic [DW-1:0] d);
    req_v[i]               = 1'b1;
    req_fp[i]              = fp;
    req_rd[i*RW +: RW]     = rd;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic expect_wb(input string tag, input logic [1:0] src, input logic fp,
                           input logic [RW-1:0] rd, input logic [DW-1:0] d);
    check({tag, ".v"},    128'(wb_v),    128'(1'b1));
    check({tag, ".src"},  128'(wb_src),  128'(src));
    check({tag, ".fp"},   128'(wb_fp),   128'(fp));
    check({tag, ".rd"},   128'(wb_rd),   128'(rd));
    check({tag, ".data"}, 128'(wb_data), 128'(d));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".v"},    128'(wb_v), 128'(1'b0));
    check({tag, ".idle"}, 128'(idle), 128'(1'b1));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req_v    = '0;
    req_fp   = '0;
    req_rd   = '0;
    req_data = '0;
    wb_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    do_reset();

    // 1: reset state
    check("rst.v",     128'(wb_v),      128'(1'b0));
    check("rst.idle",  128'(idle),      128'(1'b1));
    check("rst.ready", 128'(req_ready), 128'(3'b111));
    check("rst.fp",    128'(wb_fp),     128'(1'b0));
    check("rst.rd",    128'(wb_rd),     128'(5'd0));
    check("rst.data",  128'(wb_data),   128'(66'd0));
    check("rst.src",   128'(wb_src),    128'(2'd0));

    // 2: single push from idiv, one cycle of buffering before output
    drive(e_late_wb_idiv, 1'b0, 5'd5, 66'h2A);
    step();
    req_v = '0;
    check("single.v_n",    128'(wb_v), 128'(1'b0));
    check("single.idle_n", 128'(idle), 128'(1'b0));
    step();
    expect_wb("single", 2'd1, 1'b0, 5'd5, 66'h2A);
    step();
    expect_empty("single.drain");

    // 3a: pointer at 0 after reset, all three push together -> 0,1,2
    do_reset();
    drive(0, 1'b0, 5'd7, 66'h100);
    drive(1, 1'b0, 5'd8, 66'h101);
    drive(2, 1'b1, 5'd9, 66'h3_0000_0000_0000_0102);
    step();
    req_v = '0;
    check("rr0.v_n", 128'(wb_v), 128'(1'b0));
    step();
    expect_wb("rr0.g0", 2'd0, 1'b0, 5'd7, 66'h100);
    step();
    expect_wb("rr0.g1", 2'd1, 1'b0, 5'd8, 66'h101);
    step();
    expect_wb("rr0.g2", 2'd2, 1'b1, 5'd9, 66'h3_0000_0000_0000_0102);
    step();
    expect_empty("rr0.drain");

    // 3b: move pointer to 2 with a lone producer-1 op, then all three -> 2,0,1
    drive(1, 1'b0, 5'd1, 66'h55);
    step();
    req_v = '0;
    step();
    expect_wb("rr2.pre", 2'd1, 1'b0, 5'd1, 66'h55);
    step();
    drive(0, 1'b0, 5'd10, 66'h200);
    drive(1, 1'b1, 5'd11, 66'h201);
    drive(2, 1'b0, 5'd12, 66'h202);
    step();
    req_v = '0;
    step();
    expect_wb("rr2.g2", 2'd2, 1'b0, 5'd12, 66'h202);
    step();
    expect_wb("rr2.g0", 2'd0, 1'b0, 5'd10, 66'h200);
    step();
    expect_wb("rr2.g1", 2'd1, 1'b1, 5'd11, 66'h201);
    step();
    expect_empty("rr2.drain");

    // 4: output stalled 4 cycles while dcache pushes A, B, C
    wb_ready = 1'b0;
    drive(0, 1'b0, 5'd20, 66'hA);
    step();
    check("stall.rdy1", 128'(req_ready[0]), 128'(1'b1));
    drive(0, 1'b0, 5'd21, 66'hB);
    step();
    expect_wb("stall.A1", 2'd0, 1'b0, 5'd20, 66'hA);
    drive(0, 1'b0, 5'd22, 66'hC);
    step();
    req_v = '0;
    check("stall.full", 128'(req_ready[0]), 128'(1'b0));
    expect_wb("stall.A2", 2'd0, 1'b0, 5'd20, 66'hA);
    step();
    check("stall.full2", 128'(req_ready[0]), 128'(1'b0));
    expect_wb("stall.A3", 2'd0, 1'b0, 5'd20, 66'hA);
    wb_ready = 1'b1;
    step();
    expect_wb("stall.B", 2'd0, 1'b0, 5'd21, 66'hB);
    check("stall.rdy2", 128'(req_ready[0]), 128'(1'b1));
    step();
    expect_wb("stall.C", 2'd0, 1'b0, 5'd22, 66'hC);
    step();
    expect_empty("stall.drain");

    // 5: push to a full buffer on the cycle it pops is refused and lands next cycle
    wb_ready = 1'b0;
    drive(0, 1'b0, 5'd3, 66'h11);
    step();
    drive(0, 1'b0, 5'd4, 66'h12);
    step();
    drive(0, 1'b0, 5'd6, 66'h13);
    step();
    check("fullpop.rdy_pre", 128'(req_ready[0]), 128'(1'b0));
    expect_wb("fullpop.X", 2'd0, 1'b0, 5'd3, 66'h11);
    drive(0, 1'b1, 5'd9, 66'h14);
    wb_ready = 1'b1;
    step();
    expect_wb("fullpop.Y", 2'd0, 1'b0, 5'd4, 66'h12);
    check("fullpop.rdy_post", 128'(req_ready[0]), 128'(1'b1));
    step();
    req_v = '0;
    expect_wb("fullpop.Z", 2'd0, 1'b0, 5'd6, 66'h13);
    step();
    expect_wb("fullpop.W", 2'd0, 1'b1, 5'd9, 66'h14);
    step();
    expect_empty("fullpop.drain");

    // 6: reset with 4 entries buffered and the output valid
    wb_ready = 1'b0;
    drive(0, 1'b0, 5'd1, 66'h1);
    drive(1, 1'b0, 5'd2, 66'h2);
    drive(2, 1'b0, 5'd3, 66'h3);
    step();
    req_v[2] = 1'b0;
    drive(0, 1'b0, 5'd4, 66'h4);
    drive(1, 1'b0, 5'd5, 66'h5);
    step();
    req_v = '0;
    check("midrst.v_pre", 128'(wb_v), 128'(1'b1));
    check("midrst.idle_pre", 128'(idle), 128'(1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst.v_async", 128'(wb_v), 128'(1'b0));
    check("midrst.idle_async", 128'(idle), 128'(1'b1));
    check("midrst.ready_async", 128'(req_ready), 128'(3'b111));
    step();
    step();
    reset_n  = 1'b1;
    wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_empty("midrst.after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
